// File: rtl/regfile_pkg.sv
// regfile_pkg -- shared definitions for the multi-ported register file.
//   XLEN_DEF / NREGS_DEF : default data width and register count
//   REG0                 : index of the hard-wired zero register
//   clog2()              : address width for a given register count
package regfile_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int NREGS_DEF = 32;
  localparam int REG0      = 0;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// rf_scoreboard -- per-register busy bits for in-flight producers.
//   Clk, Rst      : clock, asynchronous active-high reset
//   SbSet, SbAdr  : mark SbAdr busy at the next edge (instruction issue)
//   WE, WAdr      : write ports; a write to r clears busy[r]
//   busy          : full busy vector (bit REG0 is always 0)
//   AllIdle       : high when no register is busy
module rf_scoreboard
  import regfile_pkg::*;
#(
  parameter int NREGS = NREGS_DEF,
  parameter int NWR   = 2,
  localparam int AW   = clog2(NREGS)
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              SbSet,
  input  logic [AW-1:0]     SbAdr,
  input  logic [NWR-1:0]    WE,
  input  logic [NWR*AW-1:0] WAdr,
  output logic [NREGS-1:0]  busy,
  output logic              AllIdle
);

  logic [NREGS-1:0] busy_nxt;

  // Clears are applied before the set so that a newly issued producer
  // keeps the register busy even when an older result lands the same cycle.
  always_comb begin
    busy_nxt = busy;
    for (int j = 0; j < NWR; j++) begin
      if (WE[j]) busy_nxt[WAdr[j*AW +: AW]] = 1'b0;
    end
    if (SbSet) busy_nxt[SbAdr] = 1'b1;
    busy_nxt[REG0] = 1'b0;
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) busy <= '0;
    else     busy <= busy_nxt;
  end

  assign AllIdle = ~|busy;

endmodule

// File: rtl/regfile_mp.sv
// regfile_mp -- multi-ported register file with issue scoreboard.
//   Clk, Rst       : clock, asynchronous active-high reset
//   RAdr / RData   : NRD combinational read ports (register 0 reads 0)
//   WE/WAdr/WData  : NWR write ports, higher port index wins on collision
//   SbSet / SbAdr  : mark a destination register busy
//   Busy           : busy bit of each read address
//   AllIdle        : high when no register is busy
// Build option: define REGFILE_BYPASS_EN to forward same-cycle write data
// (and the resulting not-busy status) onto the read ports.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int NREGS = NREGS_DEF,
  parameter int NRD   = 2,
  parameter int NWR   = 2,
  localparam int AW   = clog2(NREGS)
) (
  input  logic                Clk,
  input  logic                Rst,
  input  logic [NRD*AW-1:0]   RAdr,
  output logic [NRD*XLEN-1:0] RData,
  input  logic [NWR-1:0]      WE,
  input  logic [NWR*AW-1:0]   WAdr,
  input  logic [NWR*XLEN-1:0] WData,
  input  logic                SbSet,
  input  logic [AW-1:0]       SbAdr,
  output logic [NRD-1:0]      Busy,
  output logic                AllIdle
);

  logic [NREGS*XLEN-1:0] regs_flat;
  logic [NREGS-1:0]      busy_vec;

  rf_scoreboard #(
    .NREGS (NREGS),
    .NWR   (NWR)
  ) u_sb (
    .Clk     (Clk),
    .Rst     (Rst),
    .SbSet   (SbSet),
    .SbAdr   (SbAdr),
    .WE      (WE),
    .WAdr    (WAdr),
    .busy    (busy_vec),
    .AllIdle (AllIdle)
  );

  // Register 0 has no storage; it is a constant zero slot in the flat vector.
  assign regs_flat[REG0*XLEN +: XLEN] = '0;

  for (genvar r = 1; r < NREGS; r++) begin : g_reg
    logic            hit;
    logic [XLEN-1:0] d;
    logic [XLEN-1:0] q;

    // Later write ports overwrite earlier ones: port 1 wins a collision.
    always_comb begin
      hit = 1'b0;
      d   = '0;
      for (int j = 0; j < NWR; j++) begin
        if (WE[j] && (WAdr[j*AW +: AW] == AW'(r))) begin
          hit = 1'b1;
          d   = WData[j*XLEN +: XLEN];
        end
      end
    end

    always_ff @(posedge Clk or posedge Rst) begin
      if (Rst)      q <= '0;
      else if (hit) q <= d;
    end

    assign regs_flat[r*XLEN +: XLEN] = q;
  end

  always_comb begin
    RData = '0;
    Busy  = '0;
    for (int i = 0; i < NRD; i++) begin
      logic [AW-1:0] ra;
      ra = RAdr[i*AW +: AW];
      RData[i*XLEN +: XLEN] = regs_flat[int'(ra)*XLEN +: XLEN];
      Busy[i]               = busy_vec[ra];
`ifdef REGFILE_BYPASS_EN
      // Forwarding is suppressed in reset so outputs stay at zero.
      for (int j = 0; j < NWR; j++) begin
        if (!Rst && WE[j] && (WAdr[j*AW +: AW] == ra) && (ra != AW'(REG0))) begin
          RData[i*XLEN +: XLEN] = WData[j*XLEN +: XLEN];
          if (!(SbSet && (SbAdr == ra))) Busy[i] = 1'b0;
        end
      end
`endif
    end
  end

endmodule
